snn_ensemble_controller: RTL and testbench

Parametrised successor to the hidden-layer controller state machine of the bin-ratio ensemble SNN.
- Sequences one hidden layer across NUM_NEURONS neurons and NUM_STEPS time steps.
- Time step 0 streams CSR weight/activation entries per neuron. Later steps do a fixed accumulate-and-settle pass.
- New versus the previous generation: zero-length rows, synchronous abort, busy/step status, and parametrised sizes.
- Sits between the preprocessing block, the offset/CSR memories and the membrane-voltage memory/arithmetic unit.

---
 rtl/snn_ensemble_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_snn_ensemble_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_ensemble_controller.sv
// Hidden-layer sequencer for the bin-ratio ensemble SNN: streams CSR rows on step 0, accumulate/settle on later steps.
// Optional cycle counter output perf_cycles is enabled by defining SNN_CTRL_PERF_CNT_EN.
module snn_ensemble_controller #(
   parameter int NUM_NEURONS = 40,
   parameter int NUM_STEPS   = 4,
   parameter int OFF_W       = 10,
   parameter int CSR_AW      = 14,
   parameter int VOL_W       = 16,
   parameter int INIT_VOL    = 63,
   parameter int ACC_DELAY   = 70,
   parameter int NA          = $clog2(NUM_NEURONS),
   parameter int SA          = $clog2(NUM_STEPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pre_processing_done,
   input  logic              abort,
   input  logic [OFF_W-1:0]  off_set_value,
   output logic [NA-1:0]     offset_mem_addr,
   output logic [CSR_AW-1:0] csr_w_addr,
   output logic              w_n_a_valid,
   output logic              load_voltage,
   output logic              export_voltage,
   output logic              vol_mem_control,
   output logic [VOL_W-1:0]  init_mem_vol,
   output logic              arithm,
   output logic              current_step_finished,
   output logic              busy,
   output logic [SA-1:0]     step_idx
`ifdef SNN_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   localparam int DW = (ACC_DELAY > 1) ? $clog2(ACC_DELAY) : 1;
   localparam logic [NA-1:0]    LAST_NEURON = NA'(NUM_NEURONS - 1);
   localparam logic [SA-1:0]    LAST_STEP   = SA'(NUM_STEPS - 1);
   localparam logic [DW-1:0]    LAST_DELAY  = DW'(ACC_DELAY - 1);
   localparam logic [OFF_W-1:0] REM_ONE     = OFF_W'(1);

   typedef enum logic [3:0] {
      S_INIT,
      S_IDLE,
      S_PULL,
      S_FETCH_LD,
      S_FETCH_WAIT,
      S_FETCH_VALID,
      S_ACC_LD,
      S_ACC_OP,
      S_TIDY,
      S_DUMP0,
      S_DUMP1,
      S_DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic [NA-1:0]    neuron_cnt;
   logic [OFF_W-1:0] rem_cnt;
   logic [DW-1:0]    delay_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         state <= S_INIT;
      end else begin
         state <= next_state;
      end
   end

   // Counter updates mirror the state that is active during the cycle being closed.
   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         neuron_cnt <= '0;
         step_idx   <= '0;
         csr_w_addr <= '0;
         rem_cnt    <= '0;
         delay_cnt  <= '0;
      end else begin
         case (state)
            S_INIT: begin
               if (neuron_cnt == LAST_NEURON) begin
                  neuron_cnt <= '0;
               end else begin
                  neuron_cnt <= neuron_cnt + 1'b1;
               end
            end
            S_FETCH_LD: begin
               rem_cnt <= off_set_value;
            end
            S_FETCH_VALID: begin
               csr_w_addr <= csr_w_addr + 1'b1;
               rem_cnt    <= rem_cnt - 1'b1;
            end
            S_TIDY: begin
               if (step_idx != '0) begin
                  if (delay_cnt == LAST_DELAY) begin
                     delay_cnt <= '0;
                  end else begin
                     delay_cnt <= delay_cnt + 1'b1;
                  end
               end
            end
            S_DUMP1: begin
               if (neuron_cnt == LAST_NEURON) begin
                  neuron_cnt <= '0;
                  csr_w_addr <= '0;
                  if (step_idx == LAST_STEP) begin
                     step_idx <= '0;
                  end else begin
                     step_idx <= step_idx + 1'b1;
                  end
               end else begin
                  neuron_cnt <= neuron_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      next_state            = state;
      offset_mem_addr       = '0;
      w_n_a_valid           = 1'b0;
      load_voltage          = 1'b0;
      export_voltage        = 1'b0;
      vol_mem_control       = 1'b0;
      init_mem_vol          = '0;
      arithm                = 1'b0;
      current_step_finished = 1'b0;
      case (state)
         S_INIT: begin
            vol_mem_control = 1'b1;
            init_mem_vol    = VOL_W'(INIT_VOL);
            offset_mem_addr = neuron_cnt;
            if (neuron_cnt == LAST_NEURON) begin
               next_state = S_IDLE;
            end
         end
         S_IDLE: begin
            offset_mem_addr = neuron_cnt;
            if (pre_processing_done) begin
               next_state = S_PULL;
            end
         end
         S_PULL: begin
            offset_mem_addr = neuron_cnt;
            next_state = (step_idx == '0) ? S_FETCH_LD : S_ACC_LD;
         end
         S_FETCH_LD: begin
            load_voltage = 1'b1;
            next_state = (off_set_value == '0) ? S_TIDY : S_FETCH_WAIT;
         end
         S_FETCH_WAIT: begin
            next_state = S_FETCH_VALID;
         end
         S_FETCH_VALID: begin
            w_n_a_valid = 1'b1;
            next_state = (rem_cnt == REM_ONE) ? S_TIDY : S_FETCH_WAIT;
         end
         S_ACC_LD: begin
            load_voltage = 1'b1;
            arithm       = 1'b1;
            w_n_a_valid  = 1'b1;
            next_state   = S_ACC_OP;
         end
         S_ACC_OP: begin
            arithm     = 1'b1;
            next_state = S_TIDY;
         end
         S_TIDY: begin
            if (step_idx == '0 || delay_cnt == LAST_DELAY) begin
               next_state = S_DUMP0;
            end
         end
         S_DUMP0: begin
            export_voltage = 1'b1;
            arithm         = (step_idx != '0);
            next_state     = S_DUMP1;
         end
         S_DUMP1: begin
            offset_mem_addr = neuron_cnt;
            if (neuron_cnt == LAST_NEURON && step_idx == LAST_STEP) begin
               next_state = S_DONE;
            end else begin
               next_state = S_PULL;
            end
         end
         S_DONE: begin
            current_step_finished = 1'b1;
            next_state = S_INIT;
         end
         default: begin
            next_state = S_INIT;
         end
      endcase
   end

   assign busy = (state != S_IDLE);

`ifdef SNN_CTRL_PERF_CNT_EN
   // Counts every cycle from the first PULL up to the DONE cycle and then freezes.
   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         perf_cycles <= '0;
      end else if (state == S_IDLE && next_state == S_PULL) begin
         perf_cycles <= '0;
      end else if (state != S_INIT && state != S_IDLE && state != S_DONE &&
                   perf_cycles != 32'hFFFF_FFFF) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`else
   // Plain build: no cycle counter.
`endif

endmodule

// File: tb/tb_snn_ensemble_controller.sv
// Randomised self-checking bench: a small-sized controller is compared with a transaction-level model
// of per-neuron pulse counts and cycle totals; a default-sized instance checks the INIT sweep.
module tb_snn_ensemble_controller;

   localparam int N  = 4;
   localparam int S  = 2;
   localparam int AD = 5;
   localparam int IV = 63;
   localparam int NA = 2;
   localparam int SA = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          ppd;
   logic          abort;
   logic [9:0]    off_set_value;
   logic [NA-1:0] offset_mem_addr;
   logic [13:0]   csr_w_addr;
   logic          w_n_a_valid;
   logic          load_voltage;
   logic          export_voltage;
   logic          vol_mem_control;
   logic [15:0]   init_mem_vol;
   logic          arithm;
   logic          current_step_finished;
   logic          busy;
   logic [SA-1:0] step_idx;

   logic          d_ppd;
   logic          d_abort;
   logic [9:0]    d_off_set_value;
   logic [5:0]    d_offset_mem_addr;
   logic [13:0]   d_csr_w_addr;
   logic          d_w_n_a_valid;
   logic          d_load_voltage;
   logic          d_export_voltage;
   logic          d_vol_mem_control;
   logic [15:0]   d_init_mem_vol;
   logic          d_arithm;
   logic          d_current_step_finished;
   logic          d_busy;
   logic [1:0]    d_step_idx;
`ifdef SNN_CTRL_PERF_CNT_EN
   logic [31:0]   perf_cycles;
   logic [31:0]   d_perf_cycles;
`endif

   int checks = 0;
   int errors = 0;
   int ofs [N];

   snn_ensemble_controller #(
      .NUM_NEURONS(N), .NUM_STEPS(S), .OFF_W(10), .CSR_AW(14),
      .VOL_W(16), .INIT_VOL(IV), .ACC_DELAY(AD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pre_processing_done(ppd), .abort(abort),
      .off_set_value(off_set_value), .offset_mem_addr(offset_mem_addr),
      .csr_w_addr(csr_w_addr), .w_n_a_valid(w_n_a_valid), .load_voltage(load_voltage),
      .export_voltage(export_voltage), .vol_mem_control(vol_mem_control),
      .init_mem_vol(init_mem_vol), .arithm(arithm),
      .current_step_finished(current_step_finished), .busy(busy), .step_idx(step_idx)
`ifdef SNN_CTRL_PERF_CNT_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   snn_ensemble_controller dut_def (
      .clk(clk), .rst_n(rst_n), .pre_processing_done(d_ppd), .abort(d_abort),
      .off_set_value(d_off_set_value), .offset_mem_addr(d_offset_mem_addr),
      .csr_w_addr(d_csr_w_addr), .w_n_a_valid(d_w_n_a_valid), .load_voltage(d_load_voltage),
      .export_voltage(d_export_voltage), .vol_mem_control(d_vol_mem_control),
      .init_mem_vol(d_init_mem_vol), .arithm(d_arithm),
      .current_step_finished(d_current_step_finished), .busy(d_busy), .step_idx(d_step_idx)
`ifdef SNN_CTRL_PERF_CNT_EN
      , .perf_cycles(d_perf_cycles)
`endif
   );

   // Offset memory with one-cycle read latency.
   always @(posedge clk) off_set_value <= 10'(ofs[offset_mem_addr]);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int modelCycles();
      int total = 0;
      for (int n = 0; n < N; n++) total += 5 + 2 * ofs[n];
      total += (S - 1) * N * (5 + AD);
      return total;
   endfunction

   function automatic int rowSum();
      int sum = 0;
      for (int n = 0; n < N; n++) sum += ofs[n];
      return sum;
   endfunction

   task automatic waitIdle(input string name);
      bit idle = 1'b0;
      for (int i = 0; i < 500 && !idle; i++) begin
         @(negedge clk);
         if (busy === 1'b0) idle = 1'b1;
      end
      checkOutput({name, " reach idle"}, 32'(idle), 32'd1);
   endtask

   // After a restart, INIT must last N cycles with no stray valid pulses.
   task automatic checkRestart(input string name);
      int init_len = 0;
      int extra    = 0;
      checkOutput({name, " vol_mem_control"}, 32'(vol_mem_control), 32'd1);
      checkOutput({name, " addr"}, 32'(offset_mem_addr), 32'd0);
      checkOutput({name, " csr"}, 32'(csr_w_addr), 32'd0);
      checkOutput({name, " step"}, 32'(step_idx), 32'd0);
      checkOutput({name, " busy"}, 32'(busy), 32'd1);
`ifdef SNN_CTRL_PERF_CNT_EN
      checkOutput({name, " perf cleared"}, perf_cycles, 32'd0);
`endif
      for (int i = 0; i < 200; i++) begin
         if (vol_mem_control) init_len++;
         if (w_n_a_valid || export_voltage) extra++;
         if (!busy) break;
         @(negedge clk);
      end
      checkOutput({name, " init length"}, 32'(init_len), 32'(N));
      checkOutput({name, " stray strobes"}, 32'(extra), 32'd0);
   endtask

   task automatic applyStimulus(input string name);
      int ex = 0, nvalid = 0, lastv = 0, accld = 0, done_t = -1, kcsr = 0;
      int step, n, init_len, exp_t;
      exp_t = modelCycles();
      waitIdle(name);
      ppd = 1'b1;
      @(negedge clk);
      ppd = 1'b0;
      for (int t = 0; t < 2000; t++) begin
         if (t > 0) @(negedge clk);
         step = ex / N;
         n    = ex % N;
         if (w_n_a_valid) begin
            if (step == 0) begin
               checkOutput({name, " csr addr"}, 32'(csr_w_addr), 32'(kcsr % 16384));
               if (nvalid > 0) checkOutput({name, " valid gap"}, 32'(t - lastv), 32'd2);
               kcsr++;
               lastv = t;
            end else begin
               accld = t;
            end
            nvalid++;
         end
         if (export_voltage) begin
            checkOutput({name, " step_idx"}, 32'(step_idx), 32'(step));
            checkOutput({name, " export arithm"}, 32'(arithm), 32'(step != 0));
            checkOutput({name, " valid count"}, 32'(nvalid), 32'((step == 0) ? ofs[n] : 1));
            if (step != 0) checkOutput({name, " settle"}, 32'(t - accld), 32'(AD + 2));
            if (step == 0 && n == N - 1) checkOutput({name, " csr end"}, 32'(csr_w_addr), 32'(rowSum()));
            if (step == 1 && n == 0) checkOutput({name, " csr wrapped"}, 32'(csr_w_addr), 32'd0);
            nvalid = 0;
            ex++;
         end
         if (current_step_finished) begin
            done_t = t;
            break;
         end
      end
      checkOutput({name, " done time"}, 32'(done_t), 32'(exp_t));
      checkOutput({name, " exports"}, 32'(ex), 32'(N * S));
`ifdef SNN_CTRL_PERF_CNT_EN
      checkOutput({name, " perf"}, perf_cycles, 32'(exp_t));
`endif
      init_len = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!vol_mem_control) break;
         checkOutput({name, " init vol"}, 32'(init_mem_vol), 32'(IV));
         init_len++;
      end
      checkOutput({name, " init length"}, 32'(init_len), 32'(N));
      checkOutput({name, " idle busy"}, 32'(busy), 32'd0);
      checkOutput({name, " idle init vol"}, 32'(init_mem_vol), 32'd0);
`ifdef SNN_CTRL_PERF_CNT_EN
      checkOutput({name, " perf hold"}, perf_cycles, 32'(exp_t));
`endif
   endtask

   initial begin
      int cnt;
      int seen;
      rst_n = 1'b0; abort = 1'b0; ppd = 1'b0;
      d_ppd = 1'b0; d_abort = 1'b0; d_off_set_value = '0;
      for (int n = 0; n < N; n++) ofs[n] = 0;
      repeat (3) @(negedge clk);

      checkOutput("reset busy", 32'(busy), 32'd1);
      checkOutput("reset vol_mem_control", 32'(vol_mem_control), 32'd1);
      checkOutput("reset csr", 32'(csr_w_addr), 32'd0);
      checkOutput("reset step", 32'(step_idx), 32'd0);
      checkOutput("reset valid", 32'(w_n_a_valid), 32'd0);
      checkOutput("reset export", 32'(export_voltage), 32'd0);
      checkOutput("reset finished", 32'(current_step_finished), 32'd0);

      // Default-sized instance: 40 INIT cycles sweeping addresses 0..39.
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         if (!d_vol_mem_control) break;
         checkOutput("default init addr", 32'(d_offset_mem_addr), 32'(cnt));
         checkOutput("default init vol", 32'(d_init_mem_vol), 32'd63);
         cnt++;
         @(negedge clk);
      end
      checkOutput("default init length", 32'(cnt), 32'd40);
      checkOutput("default idle busy", 32'(d_busy), 32'd0);

      ofs = '{3, 1, 2, 5};
      applyStimulus("rows3125");
      ofs = '{0, 2, 0, 1};
      applyStimulus("rows0201");

      for (int r = 0; r < 6; r++) begin
         for (int n = 0; n < N; n++) ofs[n] = int'($urandom_range(0, 5));
         if ($urandom_range(0, 2) == 0) ofs[$urandom_range(0, N - 1)] = 0;
         applyStimulus("random");
      end

      // Abort on the second valid of a 3-entry row.
      ofs = '{3, 1, 2, 5};
      waitIdle("abort");
      ppd = 1'b1;
      @(negedge clk);
      ppd = 1'b0;
      seen = 0;
      for (int i = 0; i < 100 && seen < 2; i++) begin
         @(negedge clk);
         if (w_n_a_valid) seen++;
      end
      checkOutput("abort reached second valid", 32'(seen), 32'd2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkRestart("abort");

      // Abort together with reset mid-run.
      ppd = 1'b1;
      @(negedge clk);
      ppd = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      abort = 1'b0;
      checkRestart("reset+abort");

      ofs = '{4, 0, 1, 3};
      applyStimulus("after abort");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
